// File: rtl/pxs_pkg.sv
// Shared definitions for the PixelStream VGA source: stream layout, colours,
// 640x480@60 timing defaults and the reset value of a stream word.
package pxs_pkg;

  // Stream word geometry
  localparam int unsigned STR_W      = 26;
  localparam int unsigned CNT_W      = 10;
  localparam int unsigned RGB_W      = 3;

  // Bit positions inside the 26-bit stream word
  localparam int unsigned RGB_MSB    = 25;
  localparam int unsigned RGB_LSB    = 23;
  localparam int unsigned XC_MSB     = 22;
  localparam int unsigned XC_LSB     = 13;
  localparam int unsigned YC_MSB     = 12;
  localparam int unsigned YC_LSB     = 3;
  localparam int unsigned HS_BIT     = 2;
  localparam int unsigned VS_BIT     = 1;
  localparam int unsigned ACTIVE_BIT = 0;

  // Colour constants
  localparam logic [RGB_W-1:0] BLACK = 3'b000;
  localparam logic [RGB_W-1:0] BLUE  = 3'b001;
  localparam logic [RGB_W-1:0] GREEN = 3'b010;
  localparam logic [RGB_W-1:0] WHITE = 3'b111;

  // 640x480@60 timing defaults
  localparam int unsigned DEF_H_VISIBLE = 640;
  localparam int unsigned DEF_H_FRONT   = 16;
  localparam int unsigned DEF_H_SYNC    = 96;
  localparam int unsigned DEF_H_BACK    = 48;
  localparam int unsigned DEF_V_VISIBLE = 480;
  localparam int unsigned DEF_V_FRONT   = 10;
  localparam int unsigned DEF_V_SYNC    = 2;
  localparam int unsigned DEF_V_BACK    = 33;

  // Packed view of one stream word; field order matches the bit positions above
  typedef struct packed {
    logic [RGB_W-1:0] rgb;
    logic [CNT_W-1:0] xc;
    logic [CNT_W-1:0] yc;
    logic             hs;
    logic             vs;
    logic             active;
  } pxs_word_t;

  // Word driven while in reset: black, origin coordinates, syncs deasserted
  function automatic pxs_word_t pxs_reset_word(input logic sync_pol);
    pxs_word_t w;
    w.rgb    = BLACK;
    w.xc     = 10'd0;
    w.yc     = 10'd0;
    w.hs     = ~sync_pol;
    w.vs     = ~sync_pol;
    w.active = 1'b0;
    return w;
  endfunction

endpackage

// File: rtl/pxs_mod_counter.sv
// Modulo-N counter with increment enable. wrap_o flags the enabled increment
// that takes the count from N-1 back to 0, so it can chain a slower counter.
module pxs_mod_counter
  import pxs_pkg::*;
#(
  parameter int unsigned N = 800,
  parameter int unsigned W = CNT_W
) (
  input  logic         clk_i,
  input  logic         rst_n,
  input  logic         en_i,
  output logic [W-1:0] cnt_o,
  output logic         wrap_o
);

  localparam logic [W-1:0] MAX = W'(N - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;
  logic         at_max_s;

  assign at_max_s = (cnt_q == MAX);
  assign wrap_o   = en_i & at_max_s;
  assign cnt_o    = cnt_q;

  // Next count: hold, increment, or wrap to zero at the terminal value
  always_comb begin
    cnt_d = cnt_q;
    if (en_i) begin
      if (at_max_s) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + W'(1);
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register, cleared asynchronously
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/pxs_vga_stream_gen.sv
// PixelStream source: 640x480@60 timing counters feeding one registered
// stream word per px_clk ({RGB, XC, YC, HS, VS, Active}) plus a start-of-frame
// pulse aligned with the XC=0/YC=0 word.
// Optional feature: define PXS_COLORBARS_EN to replace the flat BG_COLOR with
// eight vertical colour bars (bar index 0..7 across the visible width).
module pxs_vga_stream_gen
  import pxs_pkg::*;
#(
  parameter int unsigned      H_VISIBLE = DEF_H_VISIBLE,
  parameter int unsigned      H_FRONT   = DEF_H_FRONT,
  parameter int unsigned      H_SYNC    = DEF_H_SYNC,
  parameter int unsigned      H_BACK    = DEF_H_BACK,
  parameter int unsigned      V_VISIBLE = DEF_V_VISIBLE,
  parameter int unsigned      V_FRONT   = DEF_V_FRONT,
  parameter int unsigned      V_SYNC    = DEF_V_SYNC,
  parameter int unsigned      V_BACK    = DEF_V_BACK,
  parameter logic             SYNC_POL  = 1'b0,
  parameter logic [RGB_W-1:0] BG_COLOR  = 3'b000
) (
  input  logic             px_clk,
  input  logic             rst_n,
  output logic [STR_W-1:0] RGBStr_o,
  output logic             sof_o
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [CNT_W-1:0] H_VIS_L  = CNT_W'(H_VISIBLE);
  localparam logic [CNT_W-1:0] V_VIS_L  = CNT_W'(V_VISIBLE);
  localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_VISIBLE + H_FRONT);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_VISIBLE + V_FRONT);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_VISIBLE + V_FRONT + V_SYNC - 1);

  logic [CNT_W-1:0] h_cnt_s;
  logic [CNT_W-1:0] v_cnt_s;
  logic             h_wrap_s;
  logic             v_wrap_s;

  logic             active_s;
  logic             hs_s;
  logic             vs_s;
  logic [RGB_W-1:0] vis_color_s;
  logic [RGB_W-1:0] rgb_s;

  pxs_word_t word_d;
  pxs_word_t word_q;
  logic      sof_q;
  // Set when the counters will sit at the frame origin on the next edge
  logic      sof_pend_q;

  // Horizontal pixel counter, always running
  pxs_mod_counter #(
    .N (H_TOTAL),
    .W (CNT_W)
  ) u_h_cnt (
    .clk_i  (px_clk),
    .rst_n  (rst_n),
    .en_i   (1'b1),
    .cnt_o  (h_cnt_s),
    .wrap_o (h_wrap_s)
  );

  // Vertical line counter, advances at the end of each line
  pxs_mod_counter #(
    .N (V_TOTAL),
    .W (CNT_W)
  ) u_v_cnt (
    .clk_i  (px_clk),
    .rst_n  (rst_n),
    .en_i   (h_wrap_s),
    .cnt_o  (v_cnt_s),
    .wrap_o (v_wrap_s)
  );

`ifdef PXS_COLORBARS_EN
  localparam int unsigned      BAR_W   = H_VISIBLE / 8;
  localparam logic [CNT_W-1:0] BAR_MAX = CNT_W'(BAR_W - 1);

  logic [RGB_W-1:0] bar_q;
  logic [RGB_W-1:0] bar_d;
  logic [CNT_W-1:0] sub_q;
  logic [CNT_W-1:0] sub_d;

  // Bar tracking: restart with the line, step the bar index every BAR_W pixels
  always_comb begin
    bar_d = bar_q;
    sub_d = sub_q;
    if (h_wrap_s) begin
      bar_d = 3'd0;
      sub_d = '0;
    end else if (sub_q == BAR_MAX) begin
      bar_d = bar_q + 3'd1;
      sub_d = '0;
    end else begin
      sub_d = sub_q + 10'd1;
    end
  end

  // Bar index and pixel sub-counter registers
  always_ff @(posedge px_clk or negedge rst_n) begin
    if (!rst_n) begin
      bar_q <= 3'd0;
      sub_q <= '0;
    end else begin
      bar_q <= bar_d;
      sub_q <= sub_d;
    end
  end

  assign vis_color_s = bar_q;
`else
  assign vis_color_s = BG_COLOR;
`endif

  // Visible-area and sync decode from the current counter values
  always_comb begin
    active_s = (h_cnt_s < H_VIS_L) && (v_cnt_s < V_VIS_L);
    if ((h_cnt_s >= HS_START) && (h_cnt_s <= HS_END)) begin
      hs_s = SYNC_POL;
    end else begin
      hs_s = ~SYNC_POL;
    end
    if ((v_cnt_s >= VS_START) && (v_cnt_s <= VS_END)) begin
      vs_s = SYNC_POL;
    end else begin
      vs_s = ~SYNC_POL;
    end
  end

  // Colour gating: blanking is always black
  always_comb begin
    if (active_s) begin
      rgb_s = vis_color_s;
    end else begin
      rgb_s = BLACK;
    end
  end

  // Assemble the next stream word
  always_comb begin
    word_d        = pxs_reset_word(SYNC_POL);
    word_d.rgb    = rgb_s;
    word_d.xc     = h_cnt_s;
    word_d.yc     = v_cnt_s;
    word_d.hs     = hs_s;
    word_d.vs     = vs_s;
    word_d.active = active_s;
  end

  // Output register; sof follows the origin flag so it lines up with XC=0/YC=0
  always_ff @(posedge px_clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q     <= pxs_reset_word(SYNC_POL);
      sof_q      <= 1'b0;
      sof_pend_q <= 1'b1;
    end else begin
      word_q     <= word_d;
      sof_q      <= sof_pend_q;
      sof_pend_q <= v_wrap_s;
    end
  end

  assign RGBStr_o = word_q;
  assign sof_o    = sof_q;

endmodule
